// File: rtl/datapath_ctrl.sv
// datapath_ctrl: instruction register plus Moore FSM sequencing the lab datapath.
// Define DATAPATH_CTRL_ILLEGAL_TRAP_EN to turn err into a sticky illegal-instruction flag.
module datapath_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic        err
);
    typedef enum logic [2:0] {WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM} state_t;
    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [2:0]  opcode, rn, rd, rm;
    logic [1:0]  op, sh;
    logic        mov_imm, mov_reg, alu_ins, cmp, illegal;

    assign opcode  = ir_q[15:13];
    assign op      = ir_q[12:11];
    assign rn      = ir_q[10:8];
    assign rd      = ir_q[7:5];
    assign sh      = ir_q[4:3];
    assign rm      = ir_q[2:0];
    assign mov_imm = opcode == 3'b110 && op == 2'b10;
    assign mov_reg = opcode == 3'b110 && op == 2'b00;
    assign alu_ins = opcode == 3'b101;
    assign cmp     = alu_ins && op == 2'b01;
    assign illegal = !(mov_imm || mov_reg || alu_ins);
    assign ir_d    = (state_q == WAIT && load) ? in : ir_q;
    assign sximm8  = {{8{ir_q[7]}}, ir_q[7:0]};
    assign bsel    = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = WAIT;
        case (state_q)
            WAIT:    state_d = s ? DECODE : WAIT;
            DECODE:  state_d = mov_imm ? WR_IMM
                             : (mov_reg || (alu_ins && op == 2'b11)) ? GET_B
                             : alu_ins ? GET_A : WAIT;
            GET_A:   state_d = GET_B;
            GET_B:   state_d = EXEC;
            EXEC:    state_d = cmp ? WAIT : WR_REG;
            default: state_d = WAIT;
        endcase
    end

    always_comb begin
        w        = state_q == WAIT;
        readnum  = state_q == GET_A ? rn : state_q == GET_B ? rm : 3'b000;
        loada    = state_q == GET_A;
        loadb    = state_q == GET_B;
        loadc    = state_q == EXEC && !cmp;
        loads    = state_q == EXEC && cmp;
        asel     = state_q == EXEC && mov_reg;
        ALUop    = (state_q == EXEC && alu_ins) ? op : 2'b00;
        shift    = state_q == EXEC ? sh : 2'b00;
        writenum = state_q == WR_REG ? rd : state_q == WR_IMM ? rn : 3'b000;
        write    = state_q == WR_REG || state_q == WR_IMM;
        vsel     = state_q == WR_IMM ? 2'b10 : 2'b00;
    end

`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
    logic err_q, err_d;
    assign err_d = err_q | (state_q == DECODE && illegal);
    assign err   = err_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end
`else
    // Illegal words simply fall back to WAIT, acting as 2-cycle NOPs.
    logic unused_illegal;
    assign unused_illegal = illegal;
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: randomized scoreboard bench; per-cycle expected outputs come from an instruction-level model.
module tb_datapath_ctrl;
    logic        clk = 1'b0, reset_n = 1'b0, load = 1'b0, s = 1'b0;
    logic [15:0] in = 16'h0000;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, err;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, ALUop, shift;
    logic [15:0] sximm8;
    logic [36:0] got, mon_e;
    logic [36:0] exp_q[$], seq[$];
    logic [15:0] ir_m = 16'h0000;
    logic        err_m = 1'b0;
    int          vectors = 0, miscompares = 0;

    datapath_ctrl dut (
        .clk(clk), .reset_n(reset_n), .in(in), .load(load), .s(s), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .ALUop(ALUop), .shift(shift),
        .sximm8(sximm8), .err(err)
    );

    always #5 clk = ~clk;

    assign got = {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
                  asel, bsel, ALUop, shift, sximm8, err};

    function automatic logic [36:0] v(input logic w_e, input logic [2:0] rn_e, input logic [2:0] wn_e,
                                      input logic wr_e, input logic [1:0] vs_e, input logic la_e,
                                      input logic lb_e, input logic lc_e, input logic ls_e,
                                      input logic as_e, input logic [1:0] alu_e, input logic [1:0] sh_e);
        logic [15:0] sx;
        sx = 16'($signed(ir_m[7:0]));
        return {w_e, rn_e, wn_e, wr_e, vs_e, la_e, lb_e, lc_e, ls_e, as_e, 1'b0, alu_e, sh_e, sx, err_m};
    endfunction

    task automatic check(input string name, input logic [36:0] g, input logic [36:0] e);
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h (IR model %h)", name, $time, g, e, ir_m);
        end
    endtask

    // Expected outputs for every cycle from DECODE until the return to WAIT.
    task automatic build();
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        opc = ir_m[15:13]; op = ir_m[12:11]; rn = ir_m[10:8]; rd = ir_m[7:5]; sh = ir_m[4:3]; rm = ir_m[2:0];
        seq.delete();
        seq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (opc == 3'b110 && op == 2'b10) begin
            seq.push_back(v(0, 0, rn, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        end else if (opc == 3'b110 && op == 2'b00) begin
            seq.push_back(v(0, rm, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            seq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, sh));
            seq.push_back(v(0, 0, rd, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        end else if (opc == 3'b101) begin
            if (op != 2'b11) seq.push_back(v(0, rn, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
            seq.push_back(v(0, rm, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            seq.push_back(v(0, 0, 0, 0, 0, 0, 0, op != 2'b01, op == 2'b01, 0, op, sh));
            if (op != 2'b01) seq.push_back(v(0, 0, rd, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        end else begin
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
            err_m = 1'b1;
`endif
        end
        seq.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Called at a negedge with the DUT in WAIT; returns at the negedge it is back in WAIT.
    task automatic launch(input logic [15:0] instr, input logic ld);
        in = instr; load = ld; s = 1'b1;
        if (ld) ir_m = instr;
        build();
        foreach (seq[i]) exp_q.push_back(seq[i]);
        for (int i = 0; i < seq.size() - 1; i++) begin
            @(negedge clk);
            in = 16'($urandom); load = 1'($urandom); s = 1'($urandom);
        end
        @(negedge clk);
        load = 1'b0; s = 1'b0;
    endtask

    task automatic idle();
        in = 16'($urandom); load = 1'($urandom); s = 1'b0;
        if (load) ir_m = in;
        exp_q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic reset_mid();
        in = 16'hA148; load = 1'b1; s = 1'b1; ir_m = in;
        build();
        for (int i = 0; i < 3; i++) exp_q.push_back(seq[i]);
        @(negedge clk); in = 16'hD007; load = 1'b1; s = 1'b0;
        @(negedge clk); in = 16'hD1FE; load = 1'b1; s = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        ir_m = 16'h0000; err_m = 1'b0;
        check("reset_mid_getb", got, v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset_n = 1'b1; load = 1'b0; s = 1'b0;
    endtask

    function automatic logic [15:0] rnd_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 3))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2: r[15:13] = 3'b101;
            default: ;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("cycle", got, mon_e);
        end
    end

    initial begin
        #3;
        check("reset_async", got, v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        launch(16'hD007, 1'b1);
        launch(16'hD1FE, 1'b1);
        launch(16'hA148, 1'b1);
        launch(16'hA900, 1'b1);
        launch(16'hC000, 1'b0);
        reset_mid();
        idle();
        launch(16'hD007, 1'b0);
        launch(16'h0000, 1'b1);
        idle();
        launch(16'hD0FF, 1'b1);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            else launch(rnd_instr(), $urandom_range(0, 3) != 0);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
